// File: rtl/controlador_lavagem_pkg.sv
// Shared definitions for the wash-cycle controller: state encodings,
// state-register width and default timing constants.
package pkg_lavagem;

    localparam int unsigned LARGURA_ESTADO = 3;

    localparam int unsigned LARGURA_CONT_PADRAO     = 8;
    localparam int unsigned TEMPO_ENCHER_MAX_PADRAO = 20;
    localparam int unsigned TEMPO_LAVAGEM_PADRAO    = 10;
    localparam int unsigned TEMPO_DRENO_PADRAO      = 6;
    localparam int unsigned TIMEOUT_CENTRIF_PADRAO  = 4;

    typedef enum logic [LARGURA_ESTADO-1:0] {
        REPOUSO     = 3'd0,
        ENCHER      = 3'd1,
        LAVAR       = 3'd2,
        DRENAR      = 3'd3,
        CENTRIFUGAR = 3'd4,
        CONCLUIDO   = 3'd5,
        ERRO        = 3'd6,
        INVALIDO    = 3'd7
    } estado_t;

endpackage

// File: rtl/controlador_lavagem_temporizador.sv
// Per-state cycle counter: synchronous clear, saturating increment and a
// terminal-compare flag against a state-selected target value.
module temporizador_estado #(
    parameter int unsigned LARGURA_CONT = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    limpar,
    input  logic [LARGURA_CONT-1:0] alvo,
    output logic                    terminal
);

    logic [LARGURA_CONT-1:0] contagem;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            contagem <= '0;
        end else if (limpar) begin
            contagem <= '0;
        end else if (contagem != '1) begin
            // Saturate so long stays in REPOUSO/ERRO never wrap back to zero.
            contagem <= contagem + 1'b1;
        end
    end

    assign terminal = (contagem == alvo);

endmodule

// File: rtl/controlador_lavagem.sv
// Wash-cycle sequencer: fill, wash, drain, spin handshake with centrifugacao,
// door-open and timeout fault detection. Moore outputs decoded from state.
module controlador_lavagem
    import pkg_lavagem::*;
#(
    parameter int unsigned TEMPO_ENCHER_MAX = TEMPO_ENCHER_MAX_PADRAO,
    parameter int unsigned TEMPO_LAVAGEM    = TEMPO_LAVAGEM_PADRAO,
    parameter int unsigned TEMPO_DRENO      = TEMPO_DRENO_PADRAO,
    parameter int unsigned TIMEOUT_CENTRIF  = TIMEOUT_CENTRIF_PADRAO,
    parameter int unsigned LARGURA_CONT     = LARGURA_CONT_PADRAO
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      iniciar,
    input  logic                      porta_aberta,
    input  logic                      nivel_cheio,
    input  logic                      centrifugacao_ativa,
    output logic                      start_centrifugacao,
    output logic                      valvula_entrada,
    output logic                      motor_lavagem,
    output logic                      bomba_saida,
    output logic                      porta_travada,
    output logic                      ciclo_concluido,
    output logic                      erro,
    output logic [LARGURA_ESTADO-1:0] estado
);

    estado_t                 estado_q, estado_d;
    logic                    visto_ativo;
    logic [LARGURA_CONT-1:0] alvo;
    logic                    terminal;
    logic                    limpar;

    assign limpar = (estado_d != estado_q);

    temporizador_estado #(
        .LARGURA_CONT(LARGURA_CONT)
    ) u_temporizador (
        .clock   (clock),
        .reset_n (reset_n),
        .limpar  (limpar),
        .alvo    (alvo),
        .terminal(terminal)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q    <= REPOUSO;
            visto_ativo <= 1'b0;
        end else begin
            estado_q <= estado_d;
            if (estado_q == CENTRIFUGAR && estado_d == CENTRIFUGAR)
                visto_ativo <= visto_ativo | centrifugacao_ativa;
            else
                visto_ativo <= 1'b0;
        end
    end

    always_comb begin
        alvo = '0;
        case (estado_q)
            ENCHER:      alvo = LARGURA_CONT'(TEMPO_ENCHER_MAX - 1);
            LAVAR:       alvo = LARGURA_CONT'(TEMPO_LAVAGEM - 1);
            DRENAR:      alvo = LARGURA_CONT'(TEMPO_DRENO - 1);
            CENTRIFUGAR: alvo = LARGURA_CONT'(TIMEOUT_CENTRIF - 1);
            default:     alvo = '0;
        endcase
    end

    // Door-open check is tested first in every active state so it wins
    // over any other transition in the same cycle.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            REPOUSO:     if (iniciar && !porta_aberta) estado_d = ENCHER;
            ENCHER: begin
                if (porta_aberta)     estado_d = ERRO;
                else if (nivel_cheio) estado_d = LAVAR;
                else if (terminal)    estado_d = ERRO;
            end
            LAVAR: begin
                if (porta_aberta)  estado_d = ERRO;
                else if (terminal) estado_d = DRENAR;
            end
            DRENAR: begin
                if (porta_aberta)  estado_d = ERRO;
                else if (terminal) estado_d = CENTRIFUGAR;
            end
            CENTRIFUGAR: begin
                if (porta_aberta)
                    estado_d = ERRO;
                else if (visto_ativo && !centrifugacao_ativa)
                    estado_d = CONCLUIDO;
                else if (!visto_ativo && !centrifugacao_ativa && terminal)
                    estado_d = ERRO;
            end
            CONCLUIDO:   estado_d = REPOUSO;
            ERRO:        if (iniciar) estado_d = REPOUSO;
            default:     estado_d = ERRO;
        endcase
    end

    always_comb begin
        start_centrifugacao = 1'b0;
        valvula_entrada     = 1'b0;
        motor_lavagem       = 1'b0;
        bomba_saida         = 1'b0;
        porta_travada       = 1'b0;
        ciclo_concluido     = 1'b0;
        erro                = 1'b0;
        case (estado_q)
            ENCHER: begin
                valvula_entrada = 1'b1;
                porta_travada   = 1'b1;
            end
            LAVAR: begin
                motor_lavagem = 1'b1;
                porta_travada = 1'b1;
            end
            DRENAR: begin
                bomba_saida   = 1'b1;
                porta_travada = 1'b1;
            end
            CENTRIFUGAR: begin
                start_centrifugacao = 1'b1;
                bomba_saida         = 1'b1;
                porta_travada       = 1'b1;
            end
            CONCLUIDO:   ciclo_concluido = 1'b1;
            ERRO:        erro = 1'b1;
            default:     ;
        endcase
    end

    assign estado = estado_q;

endmodule

// File: tb/tb_controlador_lavagem.sv
// Self-checking bench: expected state traces are built from segment
// durations and compared cycle by cycle against the controller.
module tb_controlador_lavagem;

    localparam int S_REP = 0, S_ENC = 1, S_LAV = 2, S_DRE = 3,
                   S_CEN = 4, S_CON = 5, S_ERR = 6;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       iniciar = 1'b0;
    logic       porta_aberta = 1'b0;
    logic       nivel_cheio = 1'b0;
    logic       centrifugacao_ativa;
    logic       start_centrifugacao, valvula_entrada, motor_lavagem, bomba_saida;
    logic       porta_travada, ciclo_concluido, erro;
    logic [2:0] estado;

    int checks = 0;
    int failures = 0;

    // Behavioural spin unit: ativa rises spin_lat cycles after the request
    // appears and stays high for spin_dur cycles.
    int spin_lat = 1;
    int spin_dur = 5;
    int sc = 0;

    int eq[$];
    bit iq[$], pq[$], nq[$];

    controlador_lavagem dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .iniciar            (iniciar),
        .porta_aberta       (porta_aberta),
        .nivel_cheio        (nivel_cheio),
        .centrifugacao_ativa(centrifugacao_ativa),
        .start_centrifugacao(start_centrifugacao),
        .valvula_entrada    (valvula_entrada),
        .motor_lavagem      (motor_lavagem),
        .bomba_saida        (bomba_saida),
        .porta_travada      (porta_travada),
        .ciclo_concluido    (ciclo_concluido),
        .erro               (erro),
        .estado             (estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!start_centrifugacao) sc <= 0;
        else                      sc <= sc + 1;
    end

    assign centrifugacao_ativa = start_centrifugacao && (sc >= spin_lat) &&
                                 (sc < spin_lat + spin_dur);

    // {start, valvula, motor, bomba, travada, concluido, erro}
    function automatic logic [6:0] saidas_esperadas(input int st);
        case (st)
            S_ENC:   return 7'b0100100;
            S_LAV:   return 7'b0010100;
            S_DRE:   return 7'b0001100;
            S_CEN:   return 7'b1001100;
            S_CON:   return 7'b0000010;
            S_ERR:   return 7'b0000001;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check_cycle(input string tag, input int st);
        logic [6:0] obs;
        logic [6:0] exp_s;
        obs = {start_centrifugacao, valvula_entrada, motor_lavagem, bomba_saida,
               porta_travada, ciclo_concluido, erro};
        exp_s = saidas_esperadas(st);
        checks++;
        assert (estado === 3'(st)) else begin
            failures++;
            $error("FAIL %s estado got=%0d exp=%0d", tag, estado, st);
        end
        checks++;
        assert (obs === exp_s) else begin
            failures++;
            $error("FAIL %s saidas got=%b exp=%b (estado exp=%0d)", tag, obs, exp_s, st);
        end
    endtask

    task automatic push(input int st, input bit ini, input bit porta, input bit niv);
        eq.push_back(st);
        iq.push_back(ini);
        pq.push_back(porta);
        nq.push_back(niv);
    endtask

    // d: fill index at which nivel_cheio rises; L/H: spin latency/duration;
    // p: trace index where the door opens for one cycle (-1 for none).
    task automatic build(input int d, input int L, input int H, input int p);
        int fill_len, active_end, tail, n;
        eq.delete(); iq.delete(); pq.delete(); nq.delete();
        push(S_REP, 1'b1, 1'b0, 1'b0);
        fill_len = (d <= 19) ? d + 1 : 20;
        for (int k = 0; k < fill_len; k++)
            push(S_ENC, 1'($urandom % 2), 1'b0, k >= d);
        tail = S_ERR;
        if (d <= 19) begin
            repeat (10) push(S_LAV, 1'($urandom % 2), 1'b0, 1'($urandom % 2));
            repeat (6)  push(S_DRE, 1'($urandom % 2), 1'b0, 1'($urandom % 2));
            n = (L <= 3) ? L + H + 1 : 4;
            repeat (n) push(S_CEN, 1'($urandom % 2), 1'b0, 1'b0);
            tail = (L <= 3) ? S_CON : S_ERR;
        end
        active_end = eq.size();
        if (p >= 1 && p < active_end) begin
            while (eq.size() > p + 1) begin
                void'(eq.pop_back()); void'(iq.pop_back());
                void'(pq.pop_back()); void'(nq.pop_back());
            end
            pq[p] = 1'b1;
            tail = S_ERR;
        end
        push(tail, 1'b0, 1'b0, 1'b0);
        if (tail == S_ERR) begin
            n = $urandom_range(1, 3);
            repeat (n) push(S_ERR, 1'b0, 1'b0, 1'b0);
            push(S_ERR, 1'b1, 1'b0, 1'b0);
        end
        push(S_REP, 1'b0, 1'b0, 1'b0);
        push(S_REP, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run(input string tag, input int stop_at);
        for (int i = 0; i < eq.size(); i++) begin
            @(negedge clock);
            check_cycle(tag, eq[i]);
            if (i == stop_at) begin
                iniciar = 1'b0; porta_aberta = 1'b0; nivel_cheio = 1'b0;
                return;
            end
            iniciar      = iq[i];
            porta_aberta = pq[i];
            nivel_cheio  = nq[i];
        end
        iniciar = 1'b0; porta_aberta = 1'b0; nivel_cheio = 1'b0;
    endtask

    initial begin
        int d, L, H, p;

        repeat (2) @(negedge clock);
        check_cycle("reset", S_REP);
        reset_n = 1'b1;

        spin_lat = 1; spin_dur = 5;
        build(2, 1, 5, -1);
        run("ciclo_normal", -1);

        iniciar = 1'b1; porta_aberta = 1'b1;
        repeat (10) begin
            @(negedge clock);
            check_cycle("porta_repouso", S_REP);
        end
        iniciar = 1'b0; porta_aberta = 1'b0;

        build(25, 1, 5, -1);
        run("sem_nivel", -1);

        spin_lat = 9; spin_dur = 5;
        build(2, 9, 5, -1);
        run("timeout_centrif", -1);

        spin_lat = 1; spin_dur = 5;
        build(2, 1, 5, 8);
        run("porta_lavar", -1);

        build(2, 1, 5, -1);
        run("antes_reset", 23);
        #1 reset_n = 1'b0;
        #1 check_cycle("reset_assinc", S_REP);
        @(negedge clock);
        check_cycle("reset_mantido", S_REP);
        reset_n = 1'b1;
        build(2, 1, 5, -1);
        run("pos_reset", -1);

        for (int t = 0; t < 12; t++) begin
            d = $urandom_range(0, 22);
            L = $urandom_range(0, 5);
            H = $urandom_range(1, 6);
            p = ($urandom % 3 == 0) ? $urandom_range(1, 40) : -1;
            spin_lat = L; spin_dur = H;
            build(d, L, H, p);
            run($sformatf("aleatorio%0d", t), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
